// File: rtl/canvas_pkg.sv
// canvas_pkg
//   Shared definitions for the drawing canvas:
//   - state_t   : controller states (display reads never go through the FSM)
//   - DEF_*     : default geometry / brush parameters used by canvas_painter
//   - screen_to_cell : screen coordinate -> cell coordinate, -1 when outside
//   - cell_addr      : raster-order cell address y*w+x
package canvas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_PAINT_RD = 3'd2,
    ST_PAINT_WR = 3'd3,
    ST_STR_RD   = 3'd4,
    ST_STR_OUT  = 3'd5
  } state_t;

  localparam int DEF_CANVAS_W   = 28;
  localparam int DEF_CANVAS_H   = 28;
  localparam int DEF_PIX_BITS   = 8;
  localparam int DEF_SCALE_LOG2 = 3;
  localparam int DEF_ORIGIN_X   = 128;
  localparam int DEF_ORIGIN_Y   = 128;
  localparam int DEF_BRUSH_R    = 1;
  localparam int DEF_BRUSH_INC  = 128;

  // Map one screen axis onto the cell grid. A coordinate left of / above the
  // origin, or past the last cell, yields -1 so callers can test "< 0".
  function automatic int screen_to_cell(input int pos, input int origin,
                                        input int scale_log2, input int limit);
    int rel;
    rel = pos - origin;
    if (rel < 0) return -1;
    rel = rel >> scale_log2;
    if (rel >= limit) return -1;
    return rel;
  endfunction

  function automatic int cell_addr(input int x, input int y, input int w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/canvas_ram.sv
// canvas_ram
//   DEPTH x WIDTH dual-port memory with synchronous (registered) reads,
//   written so it maps onto a block RAM.
//   clk      : clock
//   addr_a   : port A read address (display path, read only)
//   rdata_a  : port A read data, one cycle after addr_a
//   addr_b   : port B address (clear / paint / stream)
//   we_b     : port B write enable
//   wdata_b  : port B write data
//   rdata_b  : port B read data (old contents on a same-cycle write)
module canvas_ram #(
  parameter int DEPTH = 784,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    addr_b,
  input  logic             we_b,
  input  logic [WIDTH-1:0] wdata_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata_a <= mem[addr_a];
  end

  always_ff @(posedge clk) begin
    if (we_b) begin
      mem[addr_b] <= wdata_b;
    end
    rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/canvas_painter.sv
// canvas_painter
//   Drawing canvas of CANVAS_W x CANVAS_H cells, PIX_BITS intensity each.
//   Paints a (2R+1)^2 brush dab at the cursor cell on frame_tick, serves the
//   scaled image to the colour path, streams the grid over valid/ready and
//   clears on request (and automatically after reset).
//   Clk, Reset_n          : clock, asynchronous active-low reset
//   DrawX, DrawY          : raster position from the VGA controller
//   pix_out, in_canvas    : cell intensity / inside-canvas flag, 1-cycle latency
//   cursor_x, cursor_y    : cursor screen position
//   paint_en, frame_tick  : paint button, per-frame paint sampling pulse
//   clear, start          : clear request, stream request (one-cycle pulses)
//   out_valid/out_ready   : stream handshake
//   out_data, out_index   : stream beat intensity and cell address
//   out_last              : beat carries the last cell
//   busy                  : controller not idle
module canvas_painter
  import canvas_pkg::*;
#(
  parameter int CANVAS_W   = DEF_CANVAS_W,
  parameter int CANVAS_H   = DEF_CANVAS_H,
  parameter int PIX_BITS   = DEF_PIX_BITS,
  parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
  parameter int ORIGIN_X   = DEF_ORIGIN_X,
  parameter int ORIGIN_Y   = DEF_ORIGIN_Y,
  parameter int BRUSH_R    = DEF_BRUSH_R,
  parameter int BRUSH_INC  = DEF_BRUSH_INC,
  localparam int CELLS     = CANVAS_W * CANVAS_H,
  localparam int ADDR_W    = $clog2(CELLS)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  output logic [PIX_BITS-1:0] pix_out,
  output logic                in_canvas,
  input  logic [9:0]          cursor_x,
  input  logic [9:0]          cursor_y,
  input  logic                paint_en,
  input  logic                frame_tick,
  input  logic                clear,
  input  logic                start,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PIX_BITS-1:0] out_data,
  output logic [ADDR_W-1:0]   out_index,
  output logic                out_last,
  output logic                busy
);

  localparam int K      = 2 * BRUSH_R + 1;
  localparam int KK     = K * K;
  localparam int CENTRE = KK / 2;
  localparam int KW     = (KK > 1) ? $clog2(KK) : 1;

  localparam logic [PIX_BITS-1:0] PIX_MAX   = '1;
  localparam logic [PIX_BITS:0]   INC_WIDE  = (PIX_BITS+1)'(BRUSH_INC);
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(CELLS - 1);

  // Controller state
  state_t              state_reg, state_next;
  logic                init_reg, init_next;
  logic                pend_clear_reg, pend_clear_next;
  logic                pend_start_reg, pend_start_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W-1:0]   out_index_reg, out_index_next;
  logic [KW-1:0]       k_reg, k_next;
  logic [9:0]          cx_reg, cx_next;
  logic [9:0]          cy_reg, cy_next;

  // Display path
  int                  disp_cx, disp_cy;
  logic                disp_hit;
  logic [ADDR_W-1:0]   disp_addr;
  logic                in_canvas_reg;

  // Cursor cell
  int                  cur_cx, cur_cy;
  logic                cur_ok;

  // Kernel search result
  logic                srch_found;
  logic [KW-1:0]       srch_k;
  logic [ADDR_W-1:0]   srch_addr;

  // Memory interface
  logic [PIX_BITS-1:0] ram_a_data;
  logic [ADDR_W-1:0]   ram_b_addr;
  logic                ram_b_we;
  logic [PIX_BITS-1:0] ram_b_wdata;
  logic [PIX_BITS-1:0] ram_b_data;

  // Dab arithmetic
  logic [PIX_BITS:0]   paint_sum;
  logic [PIX_BITS-1:0] paint_val;

  canvas_ram #(
    .DEPTH (CELLS),
    .WIDTH (PIX_BITS),
    .AW    (ADDR_W)
  ) u_ram (
    .clk     (Clk),
    .addr_a  (disp_addr),
    .rdata_a (ram_a_data),
    .addr_b  (ram_b_addr),
    .we_b    (ram_b_we),
    .wdata_b (ram_b_wdata),
    .rdata_b (ram_b_data)
  );

  // ---------------------------------------------------------------- display
  always_comb begin
    disp_cx   = screen_to_cell(int'(DrawX), ORIGIN_X, SCALE_LOG2, CANVAS_W);
    disp_cy   = screen_to_cell(int'(DrawY), ORIGIN_Y, SCALE_LOG2, CANVAS_H);
    disp_hit  = (disp_cx >= 0) && (disp_cy >= 0);
    disp_addr = '0;
    if (disp_hit) begin
      disp_addr = ADDR_W'(cell_addr(disp_cx, disp_cy, CANVAS_W));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_canvas_reg <= 1'b0;
    end else begin
      in_canvas_reg <= disp_hit;
    end
  end

  // The RAM output register has no reset, so the registered hit flag gates
  // it; this keeps pix_out at 0 both in reset and outside the canvas.
  assign in_canvas = in_canvas_reg;
  assign pix_out   = in_canvas_reg ? ram_a_data : '0;

  // ----------------------------------------------------------- cursor cell
  always_comb begin
    cur_cx = screen_to_cell(int'(cursor_x), ORIGIN_X, SCALE_LOG2, CANVAS_W);
    cur_cy = screen_to_cell(int'(cursor_y), ORIGIN_Y, SCALE_LOG2, CANVAS_H);
    cur_ok = (cur_cx >= 0) && (cur_cy >= 0);
  end

  // ---------------------------------------------------------- kernel search
  // Finds the next kernel position (raster order, dy outer, dx inner) that
  // lands on the grid, starting at 0 when triggering from IDLE and after the
  // current position otherwise. Off-grid positions are skipped here, so they
  // cost neither cycles nor RAM accesses.
  always_comb begin
    int bx, by, start_k, tx, ty;
    bx         = (state_reg == ST_IDLE) ? cur_cx : int'(cx_reg);
    by         = (state_reg == ST_IDLE) ? cur_cy : int'(cy_reg);
    start_k    = (state_reg == ST_IDLE) ? 0 : int'(k_reg) + 1;
    tx         = 0;
    ty         = 0;
    srch_found = 1'b0;
    srch_k     = '0;
    srch_addr  = '0;
    for (int k = 0; k < KK; k++) begin
      tx = bx + (k % K) - BRUSH_R;
      ty = by + (k / K) - BRUSH_R;
      if (!srch_found && (k >= start_k) &&
          (tx >= 0) && (tx < CANVAS_W) && (ty >= 0) && (ty < CANVAS_H)) begin
        srch_found = 1'b1;
        srch_k     = KW'(k);
        srch_addr  = ADDR_W'(cell_addr(tx, ty, CANVAS_W));
      end
    end
  end

  // ------------------------------------------------------- dab arithmetic
  // One extra bit catches the carry so the increment saturates at MAX.
  always_comb begin
    paint_sum = {1'b0, ram_b_data} + INC_WIDE;
    if (int'(k_reg) == CENTRE) begin
      paint_val = PIX_MAX;
    end else if (paint_sum[PIX_BITS]) begin
      paint_val = PIX_MAX;
    end else begin
      paint_val = paint_sum[PIX_BITS-1:0];
    end
  end

  // ------------------------------------------------------------ port B mux
  always_comb begin
    ram_b_addr  = addr_reg;
    if ((state_reg == ST_STR_RD) || (state_reg == ST_STR_OUT)) begin
      ram_b_addr = out_index_reg;
    end
    ram_b_we    = (state_reg == ST_CLEAR) || (state_reg == ST_PAINT_WR);
    ram_b_wdata = (state_reg == ST_CLEAR) ? '0 : paint_val;
  end

  // ---------------------------------------------------------- FSM register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= ST_IDLE;
      init_reg       <= 1'b1;   // forces a clear sweep right after reset
      pend_clear_reg <= 1'b0;
      pend_start_reg <= 1'b0;
      addr_reg       <= '0;
      out_index_reg  <= '0;
      k_reg          <= '0;
      cx_reg         <= '0;
      cy_reg         <= '0;
    end else begin
      state_reg      <= state_next;
      init_reg       <= init_next;
      pend_clear_reg <= pend_clear_next;
      pend_start_reg <= pend_start_next;
      addr_reg       <= addr_next;
      out_index_reg  <= out_index_next;
      k_reg          <= k_next;
      cx_reg         <= cx_next;
      cy_reg         <= cy_next;
    end
  end

  // ------------------------------------------------------- FSM next state
  always_comb begin
    state_next      = state_reg;
    init_next       = init_reg;
    pend_clear_next = pend_clear_reg;
    pend_start_next = pend_start_reg;
    addr_next       = addr_reg;
    out_index_next  = out_index_reg;
    k_next          = k_reg;
    cx_next         = cx_reg;
    cy_next         = cy_reg;

    case (state_reg)
      ST_IDLE: begin
        if (init_reg || clear || pend_clear_reg) begin
          state_next      = ST_CLEAR;
          addr_next       = '0;
          init_next       = 1'b0;
          pend_clear_next = 1'b0;
          // A start arriving together with a clear runs after the sweep.
          if (start) begin
            pend_start_next = 1'b1;
          end
        end else if (start || pend_start_reg) begin
          state_next      = ST_STR_RD;
          out_index_next  = '0;
          pend_start_next = 1'b0;
        end else if (frame_tick && paint_en && cur_ok && srch_found) begin
          state_next = ST_PAINT_RD;
          cx_next    = 10'(cur_cx);
          cy_next    = 10'(cur_cy);
          k_next     = srch_k;
          addr_next  = srch_addr;
        end
      end

      ST_CLEAR: begin
        if (addr_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end

      ST_PAINT_RD: begin
        state_next = ST_PAINT_WR;
      end

      ST_PAINT_WR: begin
        if (srch_found) begin
          state_next = ST_PAINT_RD;
          k_next     = srch_k;
          addr_next  = srch_addr;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_STR_RD: begin
        state_next = ST_STR_OUT;
      end

      ST_STR_OUT: begin
        if (out_ready) begin
          if (out_index_reg == LAST_ADDR) begin
            state_next = ST_IDLE;
          end else begin
            out_index_next = out_index_reg + 1'b1;
            state_next     = ST_STR_RD;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Requests arriving while busy are remembered once. A start during a
    // stream is dropped: the stream in flight already answers it.
    if (state_reg != ST_IDLE) begin
      if (clear) begin
        pend_clear_next = 1'b1;
      end
      if (start && (state_reg != ST_STR_RD) && (state_reg != ST_STR_OUT)) begin
        pend_start_next = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------- outputs
  assign out_valid = (state_reg == ST_STR_OUT);
  assign out_data  = ram_b_data;
  assign out_index = out_index_reg;
  assign out_last  = (state_reg == ST_STR_OUT) && (out_index_reg == LAST_ADDR);
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_canvas_painter.sv
module tb_canvas_painter;

  localparam int W     = 28;
  localparam int H     = 28;
  localparam int CELLS = W * H;

  logic       Clk;
  logic       Reset_n;
  logic [9:0] DrawX, DrawY, cursor_x, cursor_y;
  logic [7:0] pix_out, out_data;
  logic [9:0] out_index;
  logic       in_canvas, paint_en, frame_tick, clear, start;
  logic       out_valid, out_ready, out_last, busy;

  int model [CELLS];
  int errors = 0;
  int checks = 0;

  typedef struct { int x; int y; bit exp_in; } disp_vec_t;
  typedef struct { int x; int y; bit en; int cycles; } paint_vec_t;

  disp_vec_t  dtab [9];
  paint_vec_t ptab [6];

  canvas_painter dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .pix_out    (pix_out),
    .in_canvas  (in_canvas),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .paint_en   (paint_en),
    .frame_tick (frame_tick),
    .clear      (clear),
    .start      (start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Reference geometry: 8 screen pixels per cell, grid starts at (128,128).
  function automatic int cell_of(input int pos, input int limit);
    int c;
    if (pos < 128) return -1;
    c = (pos - 128) / 8;
    if (c >= limit) return -1;
    return c;
  endfunction

  function automatic int expect_pix(input int x, input int y);
    int cx, cy;
    cx = cell_of(x, W);
    cy = cell_of(y, H);
    if (cx < 0 || cy < 0) return 0;
    return model[cy * W + cx];
  endfunction

  // Applies a dab to the model; returns the busy cycles it should take.
  function automatic int paint_model(input int x, input int y, input bit en);
    int cx, cy, n, tx, ty;
    cx = cell_of(x, W);
    cy = cell_of(y, H);
    if (!en || cx < 0 || cy < 0) return 0;
    n = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        tx = cx + dx;
        ty = cy + dy;
        if (tx >= 0 && tx < W && ty >= 0 && ty < H) begin
          n++;
          if (dx == 0 && dy == 0) model[ty * W + tx] = 255;
          else if (model[ty * W + tx] + 128 > 255) model[ty * W + tx] = 255;
          else model[ty * W + tx] = model[ty * W + tx] + 128;
        end
      end
    end
    return 2 * n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) model[i] = 0;
  endtask

  task automatic disp_read(input int x, input int y, output int pix, output int inc);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
    pix = int'(pix_out);
    inc = int'(in_canvas);
  endtask

  task automatic check_canvas(input string tag);
    int pix, inc, x, y;
    for (int cy = 0; cy < H; cy++) begin
      for (int cx = 0; cx < W; cx++) begin
        x = 128 + cx * 8 + int'($urandom_range(0, 7));
        y = 128 + cy * 8 + int'($urandom_range(0, 7));
        disp_read(x, y, pix, inc);
        check($sformatf("%s pix cell(%0d,%0d)", tag, cx, cy), pix, model[cy * W + cx]);
      end
    end
  endtask

  task automatic count_busy(output int n);
    int w;
    n = 0;
    w = 0;
    while (!busy && w < 3) begin
      step();
      w++;
    end
    while (busy && n < 5000) begin
      n++;
      step();
    end
  endtask

  task automatic do_paint(input int x, input int y, input bit en, output int n);
    cursor_x   = 10'(x);
    cursor_y   = 10'(y);
    paint_en   = en;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    paint_en   = 1'b0;
    count_busy(n);
  endtask

  // Drains one full stream with random backpressure, optionally pulsing
  // clear or a paint tick part way through.
  task automatic run_stream(input bit do_start, input int clear_at,
                            input int paint_at, input string tag);
    int  beat, guard, held, now_v;
    bit  have_hold, sent_clear, sent_paint;
    beat = 0; guard = 0; held = 0;
    have_hold = 0; sent_clear = 0; sent_paint = 0;
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    while (beat < CELLS && guard < 20000) begin
      now_v = int'({out_valid, out_data, out_index, out_last});
      if (have_hold) begin
        check({tag, " stall hold"}, now_v, held);
        have_hold = 0;
      end
      clear = 1'b0; frame_tick = 1'b0; paint_en = 1'b0;
      if (!sent_clear && clear_at >= 0 && beat >= clear_at) begin
        clear = 1'b1;
        sent_clear = 1;
      end
      if (!sent_paint && paint_at >= 0 && beat >= paint_at) begin
        cursor_x = 10'd200; cursor_y = 10'd200;
        paint_en = 1'b1; frame_tick = 1'b1;
        sent_paint = 1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid) begin
        if (out_ready) begin
          check($sformatf("%s index beat %0d", tag, beat), int'(out_index), beat);
          check($sformatf("%s data beat %0d", tag, beat), int'(out_data), model[beat]);
          check($sformatf("%s last beat %0d", tag, beat), int'(out_last), int'(beat == CELLS - 1));
          beat++;
        end else begin
          held = now_v;
          have_hold = 1;
        end
      end
      step();
      guard++;
    end
    clear = 1'b0; frame_tick = 1'b0; paint_en = 1'b0; out_ready = 1'b0;
    check({tag, " beats delivered"}, beat, CELLS);
  endtask

  initial begin
    int n, pix, inc, x, y, w;
    bit en;

    dtab[0] = '{100, 200, 1'b0};
    dtab[1] = '{127, 128, 1'b0};
    dtab[2] = '{128, 128, 1'b1};
    dtab[3] = '{351, 351, 1'b1};
    dtab[4] = '{352, 200, 1'b0};
    dtab[5] = '{200, 352, 1'b0};
    dtab[6] = '{218, 168, 1'b1};
    dtab[7] = '{300, 127, 1'b0};
    dtab[8] = '{1023, 1023, 1'b0};

    // (218-128)>>3 = 11, (168-128)>>3 = 5: full 3x3 dab -> 18 cycles.
    ptab[0] = '{218, 168, 1'b1, 18};
    ptab[1] = '{218, 168, 1'b1, 18};
    ptab[2] = '{128, 128, 1'b1, 8};
    ptab[3] = '{351, 351, 1'b1, 8};
    ptab[4] = '{100, 200, 1'b1, 0};
    ptab[5] = '{200, 200, 1'b0, 0};

    Reset_n = 1'b0;
    DrawX = '0; DrawY = '0; cursor_x = '0; cursor_y = '0;
    paint_en = 0; frame_tick = 0; clear = 0; start = 0; out_ready = 0;
    model_clear();
    repeat (3) step();

    // Reset state
    check("reset busy", int'(busy), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_last", int'(out_last), 0);
    check("reset in_canvas", int'(in_canvas), 0);
    check("reset pix_out", int'(pix_out), 0);
    check("reset out_index", int'(out_index), 0);

    // Post-reset clear sweep
    Reset_n = 1'b1;
    count_busy(n);
    check("boot clear busy cycles", n, CELLS);
    check_canvas("boot");

    // Paint table
    for (int i = 0; i < 6; i++) begin
      do_paint(ptab[i].x, ptab[i].y, ptab[i].en, n);
      check($sformatf("paint busy vec %0d", i), n, ptab[i].cycles);
      void'(paint_model(ptab[i].x, ptab[i].y, ptab[i].en));
    end

    // Hand-picked cells after the table
    disp_read(218, 168, pix, inc); check("centre (11,5) saturated", pix, 255);
    disp_read(209, 161, pix, inc); check("neighbour (10,4) saturated", pix, 255);
    disp_read(235, 168, pix, inc); check("outside dab (13,5)", pix, 0);
    disp_read(130, 130, pix, inc); check("corner centre (0,0)", pix, 255);
    disp_read(137, 137, pix, inc); check("corner neighbour (1,1)", pix, 128);
    disp_read(338, 338, pix, inc); check("corner neighbour (26,26)", pix, 128);
    disp_read(349, 130, pix, inc); check("no wrap (27,0)", pix, 0);
    disp_read(130, 349, pix, inc); check("no wrap (0,27)", pix, 0);
    disp_read(100, 168, pix, inc);
    check("DrawX=100 in_canvas", inc, 0);
    check("DrawX=100 pix_out", pix, 0);

    // Display table
    for (int i = 0; i < 9; i++) begin
      disp_read(dtab[i].x, dtab[i].y, pix, inc);
      check($sformatf("disp vec %0d in_canvas", i), inc, int'(dtab[i].exp_in));
      check($sformatf("disp vec %0d pix_out", i), pix,
            dtab[i].exp_in ? expect_pix(dtab[i].x, dtab[i].y) : 0);
    end

    // Random paints against the model
    for (int i = 0; i < 10; i++) begin
      x  = int'($urandom_range(110, 370));
      y  = int'($urandom_range(110, 370));
      en = ($urandom_range(0, 3) != 0);
      do_paint(x, y, en, n);
      check($sformatf("random paint %0d busy (%0d,%0d,en=%0d)", i, x, y, en), n,
            paint_model(x, y, en));
    end
    check_canvas("random");

    // Stream with stalls and a paint tick that must be ignored
    run_stream(1'b1, -1, 300, "stream1");
    check("after stream1 busy", int'(busy), 0);
    check_canvas("frozen");

    // Clear mid-stream: stream intact, then a full sweep
    run_stream(1'b1, 100, -1, "stream2");
    count_busy(n);
    check("deferred clear busy cycles", n, CELLS);
    model_clear();
    run_stream(1'b1, -1, -1, "zeros1");

    // Clear and start together: sweep first, then stream of zeros
    do_paint(250, 250, 1'b1, n);
    check("pre-clear paint busy", n, paint_model(250, 250, 1'b1));
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    count_busy(n);
    check("clear+start sweep cycles", n, CELLS);
    model_clear();
    run_stream(1'b0, -1, -1, "pending start");

    // Asynchronous reset in the middle of a stream
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin
      step();
      w++;
    end
    check("valid before async reset", int'(out_valid), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("async reset out_valid", int'(out_valid), 0);
    check("async reset busy", int'(busy), 0);
    check("async reset in_canvas", int'(in_canvas), 0);
    step();
    step();
    Reset_n = 1'b1;
    count_busy(n);
    check("re-boot clear busy cycles", n, CELLS);
    model_clear();
    run_stream(1'b1, -1, -1, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
